// File: rtl/ejecutor_tipo_r_pkg.sv
// Shared constants for the R-type executor: opcode/funct encodings,
// the FSM state type and the legality check used during decode.
package ejecutor_tipo_r_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (opcode == OP_RTYPE);
  endfunction

endpackage

// File: rtl/ejecutor_tipo_r_alu.sv
// Combinational R-type ALU. Unknown funct codes yield zero; they never
// reach writeback because decode rejects them first.
module alu_tipo_r
  import ejecutor_tipo_r_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] y
);

  logic shift_oob;
  logic lt;

  // Shifts of DATA_W or more clear the operand instead of wrapping the amount.
  assign shift_oob = ({27'b0, shamt} >= 32'(DATA_W));
  assign lt        = ($signed(a) < $signed(b));

  always_comb begin
    y = '0;
    case (funct)
      FN_ADD: y = a + b;
      FN_SUB: y = a - b;
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_NOR: y = ~(a | b);
      FN_SLT: y = {{(DATA_W-1){1'b0}}, lt};
      FN_SLL: y = shift_oob ? '0 : (b << shamt);
      FN_SRL: y = shift_oob ? '0 : (b >> shamt);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ejecutor_tipo_r.sv
// Multi-cycle R-type instruction executor with an internal register file,
// preload port and combinational debug read port.
//
// state  | meaning
// IDLE   | ready for an instruction; preload writes accepted
// DECODE | legality check, operands read from the register file
// EXEC   | ALU result registered, rd written, done pulsed
// WB     | writeback visible; returns to IDLE
module ejecutor_tipo_r
  import ejecutor_tipo_r_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int R0_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic                  init_we,
  input  logic [REG_ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0]     init_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [DATA_W-1:0]     result,
  output logic                  zf,
  output logic                  done,
  output logic                  ilegal,
  output logic                  busy
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  state_t                state;
  logic [5:0]            opcode_q;
  logic [5:0]            funct_q;
  logic [4:0]            shamt_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     alu_y;
  logic [DATA_W-1:0]     rf [NREGS];
  logic                  init_ok;
  logic                  rd_ok;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign dbg_data    = rf[dbg_addr];

  // Register 0 swallows writes when it is hardwired to zero.
  assign init_ok = !((R0_ZERO != 0) && (init_addr == '0));
  assign rd_ok   = !((R0_ZERO != 0) && (rd_q == '0));

  alu_tipo_r #(.DATA_W(DATA_W)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .shamt (shamt_q),
    .funct (funct_q),
    .y     (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      shamt_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      zf       <= 1'b0;
      done     <= 1'b0;
      ilegal   <= 1'b0;
    end else begin
      done   <= 1'b0;
      ilegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            opcode_q <= instr[31:26];
            rs_q     <= instr[21 +: REG_ADDR_W];
            rt_q     <= instr[16 +: REG_ADDR_W];
            rd_q     <= instr[11 +: REG_ADDR_W];
            shamt_q  <= instr[10:6];
            funct_q  <= instr[5:0];
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_legal(opcode_q, funct_q)) begin
            op_a  <= rf[rs_q];
            op_b  <= rf[rt_q];
            state <= ST_EXEC;
          end else begin
            ilegal <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result <= alu_y;
          zf     <= (alu_y == '0);
          done   <= 1'b1;
          state  <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Preloads and instruction writeback occupy different states, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if ((state == ST_IDLE) && init_we && init_ok) begin
      rf[init_addr] <= init_data;
    end else if ((state == ST_EXEC) && rd_ok) begin
      rf[rd_q] <= alu_y;
    end
  end

endmodule
